// File: rtl/hamming_pkg.sv
// Shared Hamming helpers and the serializer state type.
// Parity bits sit at the power-of-two codeword positions (1-based).
// Data bits fill the remaining positions in ascending order.
package hamming_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Smallest r such that 2**r >= dw + r + 1 (single-error-correcting code).
    function automatic int code_bits(input int dw);
        int r;
        r = 0;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= dw + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic int coded_width(input int dw);
        return dw + code_bits(dw);
    endfunction

    // 1-based codeword position of payload bit idx: the idx-th position
    // that is not a power of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 1024; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_parity.sv
// Combinational Hamming parity generator.
// parity[j] covers every payload bit whose codeword position has bit j set,
// so the padded codeword has a zero syndrome.
module hamming_parity
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int CODE_BITS = code_bits(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CODE_BITS-1:0]  parity
);

    // Codeword position of each payload bit, fixed at elaboration.
    logic [CODE_BITS-1:0] pos_bits [DATA_WIDTH];

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
        localparam int POS = data_pos(i);
        assign pos_bits[i] = CODE_BITS'(POS);
    end

    // XOR each payload bit into every parity bit that covers its position.
    always_comb begin
        // NOTE: default first so every path assigns parity and no latch is inferred.
        parity = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int j = 0; j < CODE_BITS; j++) begin
                if (pos_bits[i][j]) begin
                    parity[j] = parity[j] ^ data[i];
                end
            end
        end
    end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter, MSB first, with optional Hamming parity.
// Emits one enable strobe per bit, start on the first bit and done on the last,
// matching the deserializer's serial_in/enable/start inputs.
module serializer
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int HAS_ECC      = 0,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  serial_out_o,
    output logic                  enable_o,
    output logic                  start_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CODE_BITS = code_bits(DATA_WIDTH);
    localparam int FRAME_W   = (HAS_ECC != 0) ? DATA_WIDTH + CODE_BITS : DATA_WIDTH;
    localparam int BIT_W     = $clog2(FRAME_W + 1);
    localparam int DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLKS_PER_BIT - 1);

    logic [FRAME_W-1:0] frame;

    if (HAS_ECC != 0) begin : g_ecc
        logic [CODE_BITS-1:0] parity;
        hamming_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
            .data   (data_i),
            .parity (parity)
        );
        assign frame = {data_i, parity};
    end else begin : g_plain
        assign frame = data_i;
    end

    ser_state_t          state_q, state_n;
    logic [FRAME_W-1:0]  shreg_q, shreg_n;
    logic [BIT_W-1:0]    bit_q,   bit_n;
    logic [DIV_W-1:0]    div_q,   div_n;
    logic                strobe_n, serial_n, start_n, done_n;
    logic                strobe_q, serial_q, start_q, done_q;

    // Next-state logic; the registered outputs are derived from the next
    // state so they line up with the bit the shift register presents.
    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        bit_n   = bit_q;
        div_n   = div_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_n = SHIFT;
                    shreg_n = frame;
                    bit_n   = '0;
                    div_n   = '0;
                end
            end
            SHIFT: begin
                if (div_q == LAST_DIV) begin
                    div_n = '0;
                    if (bit_q == LAST_BIT) begin
                        state_n = IDLE;
                        bit_n   = '0;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shreg_n = shreg_q << 1;
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        strobe_n = (state_n == SHIFT) && (div_n == '0);
        serial_n = (state_n == SHIFT) && shreg_n[FRAME_W-1];
        start_n  = strobe_n && (bit_n == '0);
        done_n   = strobe_n && (bit_n == LAST_BIT);
    end

    // State, datapath and output registers; reset aborts any frame at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            strobe_q <= 1'b0;
            serial_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_n;
            shreg_q  <= shreg_n;
            bit_q    <= bit_n;
            div_q    <= div_n;
            strobe_q <= strobe_n;
            serial_q <= serial_n;
            start_q  <= start_n;
            done_q   <= done_n;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign busy_o       = (state_q == SHIFT);
    assign enable_o     = strobe_q;
    assign serial_out_o = serial_q;
    assign start_o      = start_q;
    assign done_o       = done_q;

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Transmit-side counterpart of the deserializer. Accepts one parallel word per valid/ready handshake.
- When HAS_ECC=1, appends Hamming parity bits to the word.
- Shifts the frame out MSB-first on a serial line, with a one-cycle enable strobe per bit and a start strobe on the first bit.
- Outputs connect directly to deserializer serial_in_i / enable_i / start_i.

Parameters:
- DATA_WIDTH, 8, payload width in bits; must be >= 2.
- HAS_ECC, 0, 1 = append CODE_BITS parity field, so the frame is CODED_WIDTH bits long.
- CLKS_PER_BIT, 1, clock cycles per serial bit; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  DATA_WIDTH  parallel payload.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  block can accept a word.
- serial_out_o  out  1  serial bit; drives the deserializer serial_in_i.
- enable_o  out  1  one-cycle strobe marking a valid bit on serial_out_o.
- start_o  out  1  asserted together with enable_o on the first bit of a frame.
- busy_o  out  1  a frame is in progress.
- done_o  out  1  one-cycle pulse together with the last bit's enable_o.

Behaviour:
- Reset:
  - One clock, clk_i. rst_i is asynchronous and active-high.
  - On reset, all flops clear. ready_o=1 (combinational from IDLE); all other outputs = 0.
  - State returns to IDLE.
- Frame width and format:
  - FRAME_W = DATA_WIDTH when HAS_ECC=0; FRAME_W = CODED_WIDTH when HAS_ECC=1.
  - Frame = {data_i, parity[CODE_BITS-1:0]}; with no ECC, frame = data_i.
  - Transmission order is frame[FRAME_W-1] first, down to frame[0] last. This matches the deserializer's left shift and hamming_pad input split.
  - Parity is computed combinationally from data_i at acceptance and registered into the shift register with the data.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ready_o=1.
  - valid_i && ready_o at cycle N: load the shift register with the frame, bit_cnt=0, div_cnt=0, go to SHIFT.
- SHIFT:
  - ready_o=0, busy_o=1. valid_i is ignored.
  - A bit strobe is issued when div_cnt==0. On that cycle:
    - enable_o=1;
    - serial_out_o = current MSB of the shift register;
    - start_o = (bit_cnt==0);
    - done_o = (bit_cnt==FRAME_W-1).
  - div_cnt counts 0..CLKS_PER_BIT-1 and wraps.
  - On the wrap (or every cycle when CLKS_PER_BIT=1), the shift register shifts left and bit_cnt increments.
  - serial_out_o is held stable for all CLKS_PER_BIT cycles of a bit.
  - After the cycle in which the last bit completes its CLKS_PER_BIT window, go to IDLE.
- Latency:
  - First bit (start_o, enable_o) at cycle N+1.
  - Bit k strobed at cycle N+1+k*CLKS_PER_BIT.
  - ready_o returns at cycle N+1+FRAME_W*CLKS_PER_BIT.
  - Minimum gap between frames is 1 idle cycle.
- Outputs enable_o, start_o, done_o, serial_out_o are registered. serial_out_o=0 in IDLE.
- Boundary conditions:
  - CLKS_PER_BIT=1: enable_o is high continuously for FRAME_W cycles.
  - valid_i held high across frames: the next word is accepted on the first IDLE cycle.
  - Reset mid-frame: the frame is aborted immediately. No done_o is issued; the partial frame is dropped, and the deserializer stays not-valid because no further bits are strobed.
  - data_i changing after acceptance has no effect on the frame in flight.
- Widths:
  - bit_cnt is $clog2(FRAME_W+1) bits.
  - div_cnt is max(1,$clog2(CLKS_PER_BIT)) bits.
  - No overflow: both counters are compared against their bound before incrementing.

Decomposition:
- Shared package hamming_pkg:
  - CODE_BITS and CODED_WIDTH as functions of DATA_WIDTH;
  - the parity-position helper function;
  - serializer state enum typedef (IDLE, SHIFT).
- One sub-module, hamming_parity:
  - combinational; DATA_WIDTH in, CODE_BITS out;
  - produces the parity field so that hamming_pad followed by hamming_decode reports num_errors_o=0;
  - instantiated only under HAS_ECC=1 (generate).

Test Plan:
1. DATA_WIDTH=8, HAS_ECC=0, CLKS_PER_BIT=1; accept 0xA5 at cycle N:
   - serial_out_o = 1,0,1,0,0,1,0,1 on cycles N+1..N+8 with enable_o high;
   - start_o only at N+1, done_o only at N+8;
   - ready_o=1 at N+9.
2. Loopback into the deserializer (same params), words 0x00, 0xFF, 0x5A back-to-back with valid_i held high:
   - deserializer valid_o pulses three times with parallel_out_o = 0x00, 0xFF, 0x5A in order.
3. CLKS_PER_BIT=4, data 0x81:
   - enable_o at N+1, N+5, …, N+29;
   - serial_out_o is 1 for N+1..N+4, 0 for N+5..N+28, 1 for N+29..N+32;
   - ready_o at N+33.
4. HAS_ECC=1 loopback of 0x3C:
   - deserializer parallel_out_o=0x3C, num_errors_o=0.
   - With the bench inverting frame bit 5 on the wire: parallel_out_o=0x3C, num_errors_o=1.
5. Assert rst_i asynchronously (mid-cycle) at bit 3 of a frame:
   - all outputs go 0 and ready_o goes 1 without waiting for a clock edge;
   - no done_o is issued;
   - a subsequent 0xC3 transmits correctly.
6. valid_i pulsed during SHIFT with data 0x11:
   - ignored;
   - only the original frame is emitted, and ready_o stays 0 until the frame ends.
